muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL expose: clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL expose: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL expose: io_req_valid  input  1  operation request present.
REQ-004 SHALL expose: io_req_ready  output  1  unit can accept a request.
REQ-005 SHALL expose: io_req_fn  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL expose: io_req_in_a  input  32  rs1 operand, from the same operand path as the ALU in_a.
REQ-007 SHALL expose: io_req_in_b  input  32  rs2 operand, from the same operand path as the ALU in_b.
REQ-008 SHALL expose: io_kill  input  1  abort the in-flight operation (pipeline flush).
REQ-009 SHALL expose: io_resp_valid  output  1  result available.
REQ-010 SHALL expose: io_resp_ready  input  1  consumer (writeback mux) accepts the result.
REQ-011 SHALL expose: io_resp_out  output  32  result word.

Function
REQ-012 SHALL implement states IDLE, BUSY, FIX, DONE; io_req_ready = (state == IDLE); io_resp_valid = (state == DONE).
REQ-013 SHALL accept a request when io_req_valid && io_req_ready; fn and both operands latched at that edge; later input changes ignored.
REQ-014 SHALL, on accept in cycle T, occupy BUSY in cycles T+1..T+32 (6-bit counter 0..31, one iteration per cycle), FIX in T+33, DONE from T+34.
REQ-015 Multiply SHALL be radix-2 shift-add on operand magnitudes with a 64-bit product; MUL returns bits [31:0], MULH/MULHSU/MULHU return bits [63:32].
REQ-016 Signedness SHALL be: MULH a and b signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU unsigned; DIV/REM signed.
REQ-017 Divide SHALL be restoring, one quotient bit per cycle, on magnitudes; FIX SHALL negate the quotient when the operand signs differ and negate the remainder when the dividend is negative.
REQ-018 Divide by zero SHALL give quotient 0xFFFFFFFF (DIV and DIVU) and remainder = dividend (REM and REMU).
REQ-019 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give DIV 0x80000000 and REM 0x00000000.
REQ-020 In DONE, io_resp_out SHALL hold stable until io_resp_valid && io_resp_ready, then go to IDLE; the next request is accepted no earlier than the following cycle.
REQ-021 io_resp_out SHALL be 0 in every state other than DONE.
REQ-022 io_kill SHALL, in any state, force IDLE at the next edge with no response; io_kill has priority over accept and over the response handshake.
REQ-023 io_req_valid while not in IDLE SHALL be ignored, with no side effects.

Reset
REQ-024 reset SHALL force IDLE, counter 0, internal registers 0, io_req_ready 1, io_resp_valid 0, io_resp_out 0 at the next edge.
REQ-025 Reset mid-operation SHALL discard the operation with no response; reset has priority over io_kill and all handshakes.

Configuration
REQ-026 Macro MULDIV_EARLY_OUT_EN defined: divide with b == 0, and multiply with a == 0 or b == 0, SHALL skip BUSY and FIX and reach DONE at T+1 with the REQ-018 or zero result.
REQ-027 Macro MULDIV_EARLY_OUT_EN undefined: every operation SHALL take the full REQ-014 latency; results are identical in both builds.

Verification
REQ-028 MUL a=7, b=0xFFFFFFFD accepted at T -> io_resp_valid rises at T+34, io_resp_out 0xFFFFFFEB; io_req_ready low T+1..T+34.
REQ-029 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-030 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 % 7 -> 2.
REQ-031 DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 % 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; with MULDIV_EARLY_OUT_EN, DIVU 5 / 0 gives io_resp_valid at T+1.
REQ-032 io_resp_ready held low for 5 cycles in DONE -> io_resp_out stable and io_req_ready low throughout; handshake -> IDLE next cycle.
REQ-033 reset (or io_kill) asserted in BUSY cycle T+10 -> IDLE at the next edge, io_resp_valid never rises; a new MUL 3*4 then returns 12 at full latency.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle on
// operand magnitudes, followed by a single sign-fixup cycle.
// Optional build macro MULDIV_EARLY_OUT_EN: divide by zero and multiply by
// zero complete in one cycle instead of the full iterative latency.
module muldiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [2:0]  io_req_fn,
  input  logic [31:0] io_req_in_a,
  input  logic [31:0] io_req_in_b,
  input  logic        io_kill,
  output logic        io_resp_valid,
  input  logic        io_resp_ready,
  output logic [31:0] io_resp_out
);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [2:0]  fn_q;
  logic [31:0] opnd_q;    // multiplicand (multiply) or divisor (divide)
  logic [63:0] acc_q;     // product, or {remainder, quotient}
  logic        neg_q;     // negate product / quotient in FIX
  logic        rneg_q;    // negate remainder in FIX
  logic [31:0] result_q;

  // Request decode: signedness per funct3 and operand magnitudes.
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  // One multiply step and one divide step computed from the current state.
  logic [32:0] mul_sum;
  logic [63:0] mul_step_d;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] div_step_d;

  // Sign-corrected final result computed in FIX.
  logic [63:0] prod_fix;
  logic [31:0] quo_raw, rem_raw;
  logic [31:0] result_d;

  // Decode signedness and take magnitudes of the incoming operands.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned; otherwise a latch is inferred.
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (io_req_fn)
      3'd1:          begin a_signed = 1'b1; b_signed = 1'b1; end  // MULH
      3'd2:          a_signed = 1'b1;                             // MULHSU
      3'd4, 3'd6:    begin a_signed = 1'b1; b_signed = 1'b1; end  // DIV, REM
      default:       ;
    endcase
    a_neg = a_signed & io_req_in_a[31];
    b_neg = b_signed & io_req_in_b[31];
    a_mag = a_neg ? (32'd0 - io_req_in_a) : io_req_in_a;
    b_mag = b_neg ? (32'd0 - io_req_in_b) : io_req_in_b;
  end

  // Iteration datapath: shift-add multiply step and restoring divide step.
  always_comb begin
    // Multiply: add multiplicand into the high half when the LSB is set,
    // then shift the 65-bit {carry, product} right by one.
    mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_step_d = {mul_sum, acc_q[31:1]};
    // Divide: shift the next dividend bit into the partial remainder and
    // keep the subtraction only when it does not go negative.
    div_shift  = {acc_q[63:32], acc_q[31]};
    div_diff   = {1'b0, div_shift} - {2'b00, opnd_q};
    if (!div_diff[33]) begin
      div_step_d = {div_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      div_step_d = {div_shift[31:0], acc_q[30:0], 1'b0};
    end
  end

  // Sign fixup and selection of the architectural result.
  always_comb begin
    prod_fix = neg_q ? (64'd0 - acc_q) : acc_q;
    quo_raw  = acc_q[31:0];
    rem_raw  = acc_q[63:32];
    result_d = 32'd0;
    if (fn_q[2]) begin
      if (fn_q[1]) begin
        // Remainder sign follows the dividend; divide by zero naturally
        // leaves the dividend here.
        result_d = rneg_q ? (32'd0 - rem_raw) : rem_raw;
      end else if (opnd_q == 32'd0) begin
        result_d = 32'hFFFF_FFFF;
      end else begin
        result_d = neg_q ? (32'd0 - quo_raw) : quo_raw;
      end
    end else begin
      result_d = (fn_q[1:0] == 2'd0) ? prod_fix[31:0] : prod_fix[63:32];
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic        early_hit;
  logic [31:0] early_result;

  // Detect operations whose result is known from the operands alone.
  always_comb begin
    early_hit    = 1'b0;
    early_result = 32'd0;
    if (io_req_fn[2]) begin
      early_hit    = (io_req_in_b == 32'd0);
      early_result = io_req_fn[1] ? io_req_in_a : 32'hFFFF_FFFF;
    end else begin
      early_hit    = (io_req_in_a == 32'd0) || (io_req_in_b == 32'd0);
      early_result = 32'd0;
    end
  end
`endif

  // Control FSM and datapath registers; reset beats kill beats handshakes.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      fn_q     <= 3'd0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 32'd0;
    end else if (io_kill) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io_req_valid) begin
            fn_q   <= io_req_fn;
            opnd_q <= io_req_fn[2] ? b_mag : a_mag;
            acc_q  <= {32'd0, io_req_fn[2] ? a_mag : b_mag};
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            cnt_q  <= 6'd0;
`ifdef MULDIV_EARLY_OUT_EN
            if (early_hit) begin
              result_q <= early_result;
              state_q  <= DONE;
            end else begin
              state_q  <= BUSY;
            end
`else
            state_q <= BUSY;
`endif
          end
        end
        BUSY: begin
          acc_q <= fn_q[2] ? div_step_d : mul_step_d;
          if (cnt_q == 6'd31) begin
            cnt_q   <= 6'd0;
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        FIX: begin
          result_q <= result_d;
          state_q  <= DONE;
        end
        DONE: begin
          if (io_resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_req_ready  = (state_q == IDLE);
  assign io_resp_valid = (state_q == DONE);
  assign io_resp_out   = (state_q == DONE) ? result_q : 32'd0;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a scoreboard queue; a negedge monitor
// checks response latency, data, and the zero output outside DONE.
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_req_valid;
  logic        io_req_ready;
  logic [2:0]  io_req_fn;
  logic [31:0] io_req_in_a;
  logic [31:0] io_req_in_b;
  logic        io_kill;
  logic        io_resp_valid;
  logic        io_resp_ready;
  logic [31:0] io_resp_out;

  muldiv_unit dut (
    .clock         (clock),
    .reset         (reset),
    .io_req_valid  (io_req_valid),
    .io_req_ready  (io_req_ready),
    .io_req_fn     (io_req_fn),
    .io_req_in_a   (io_req_in_a),
    .io_req_in_b   (io_req_in_b),
    .io_kill       (io_kill),
    .io_resp_valid (io_resp_valid),
    .io_resp_ready (io_resp_ready),
    .io_resp_out   (io_resp_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    int          issue;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic prev_valid = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100; i++) begin
      if (io_req_ready) return;
      tick();
    end
    check("wait_ready_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: latency on the rising edge of valid, data on each handshake.
  always @(negedge clock) begin
    if (!reset) begin
      if (!io_resp_valid) check("out_zero_when_not_done", io_resp_out, 32'd0);
      if (io_resp_valid && !prev_valid) begin
        if (sb.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
        else check({sb[0].name, "_lat"}, cyc - sb[0].issue, sb[0].lat);
      end
      if (io_resp_valid && io_resp_ready) begin
        if (sb.size() > 0) begin
          check(sb[0].name, io_resp_out, sb[0].data);
          void'(sb.pop_front());
        end
      end
    end
    prev_valid = io_resp_valid;
  end

  function automatic int exp_latency(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    bit early;
    early = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
    early = fn[2] ? (b == 32'd0) : ((a == 32'd0) || (b == 32'd0));
`endif
    return early ? 1 : 34;
  endfunction

  // Issue one request and wait for its response; hold_valid keeps junk
  // requests asserted while the unit is busy.
  task automatic do_op(input string name, input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit hold_valid);
    exp_t e;
    bit   saw_ready;
    bit   got;
    wait_ready();
    io_req_valid = 1'b1;
    io_req_fn    = fn;
    io_req_in_a  = a;
    io_req_in_b  = b;
    e.data  = exp;
    e.issue = cyc;
    e.lat   = exp_latency(fn, a, b);
    e.name  = name;
    sb.push_back(e);
    tick();
    io_req_valid = hold_valid;
    io_req_fn    = ~fn;
    io_req_in_a  = 32'h1234_5678;
    io_req_in_b  = 32'h0000_0003;
    saw_ready = 1'b0;
    got       = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (io_req_ready) saw_ready = 1'b1;
      if (io_resp_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    io_req_valid = 1'b0;
    check({name, "_busy_ready"}, {31'd0, saw_ready}, 32'd0);
    if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
    tick();
  endtask

  task automatic issue_only(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                            output int issue_cyc);
    wait_ready();
    io_req_valid = 1'b1;
    io_req_fn    = fn;
    io_req_in_a  = a;
    io_req_in_b  = b;
    issue_cyc    = cyc;
    tick();
    io_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    check("watchdog", 32'd0, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    int  t0;
    bit  got;
    reset         = 1'b1;
    io_req_valid  = 1'b0;
    io_req_fn     = 3'd0;
    io_req_in_a   = 32'd0;
    io_req_in_b   = 32'd0;
    io_kill       = 1'b0;
    io_resp_ready = 1'b1;
    repeat (3) tick();
    check("reset_req_ready",  {31'd0, io_req_ready},  32'd1);
    check("reset_resp_valid", {31'd0, io_resp_valid}, 32'd0);
    check("reset_resp_out",   io_resp_out,            32'd0);
    reset = 1'b0;
    tick();

    // Arithmetic vectors.
    do_op("mul_7_m3",      F_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    do_op("mulhu_m1_m1",   F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    do_op("mulh_m1_m1",    F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    do_op("mulhsu_m1_2",   F_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0);
    do_op("mulhsu_min_u",  F_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_op("mul_zero",      F_MUL,    32'd0,         32'd5,         32'd0,         1'b0);
    do_op("div_m7_2",      F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
    do_op("rem_m7_2",      F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
    do_op("divu_100_7",    F_DIVU,   32'd100,       32'd7,         32'd14,        1'b1);
    do_op("remu_100_7",    F_REMU,   32'd100,       32'd7,         32'd2,         1'b0);
    do_op("divu_5_0",      F_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0);
    do_op("remu_5_0",      F_REMU,   32'd5,         32'd0,         32'd5,         1'b0);
    do_op("div_m7_0",      F_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b0);
    do_op("rem_m7_0",      F_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0);
    do_op("div_ovf",       F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_op("rem_ovf",       F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

    // Back-pressure: hold the response for 5 DONE cycles.
    io_resp_ready = 1'b0;
    wait_ready();
    begin
      exp_t e;
      io_req_valid = 1'b1;
      io_req_fn    = F_DIVU;
      io_req_in_a  = 32'd100;
      io_req_in_b  = 32'd7;
      e.data = 32'd14; e.issue = cyc; e.lat = 34; e.name = "stall_divu";
      sb.push_back(e);
    end
    tick();
    io_req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (io_resp_valid) begin got = 1'b1; break; end
      tick();
    end
    if (!got) check("stall_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_stable",  io_resp_out,            32'd14);
      check("stall_req_ready",   {31'd0, io_req_ready},  32'd0);
      check("stall_resp_valid",  {31'd0, io_resp_valid}, 32'd1);
      tick();
    end
    io_resp_ready = 1'b1;
    tick();
    check("stall_idle_ready", {31'd0, io_req_ready},  32'd1);
    check("stall_idle_valid", {31'd0, io_resp_valid}, 32'd0);

    // Reset in BUSY cycle T+10 discards the operation.
    issue_only(F_MUL, 32'd3, 32'd4, t0);
    while (cyc < t0 + 10) tick();
    check("pre_reset_busy", {31'd0, io_req_ready}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("after_reset_ready", {31'd0, io_req_ready},  32'd1);
    check("after_reset_valid", {31'd0, io_resp_valid}, 32'd0);
    do_op("mul_3_4_after_reset", F_MUL, 32'd3, 32'd4, 32'd12, 1'b0);

    // Kill in BUSY cycle T+10 discards the operation.
    issue_only(F_MUL, 32'd5, 32'd6, t0);
    while (cyc < t0 + 10) tick();
    io_kill = 1'b1;
    tick();
    io_kill = 1'b0;
    check("after_kill_ready", {31'd0, io_req_ready},  32'd1);
    check("after_kill_valid", {31'd0, io_resp_valid}, 32'd0);

    // Kill beats accept in IDLE.
    io_req_valid = 1'b1;
    io_req_fn    = F_MUL;
    io_req_in_a  = 32'd9;
    io_req_in_b  = 32'd9;
    io_kill      = 1'b1;
    tick();
    io_req_valid = 1'b0;
    io_kill      = 1'b0;
    check("kill_vs_accept_ready", {31'd0, io_req_ready}, 32'd1);
    do_op("mul_3_4_after_kill", F_MUL, 32'd3, 32'd4, 32'd12, 1'b0);

    // Drain the scoreboard.
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check("sb_drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
